// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-wide RAM/IO sequencer for committed stores, loads and instruction fetches
module memory_controller #(
    parameter logic [31:0] IO_ADDR = 32'h30000,
    parameter int          XLEN    = 32,
    parameter int          ID_W    = 4,
    parameter int          OP_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            io_buffer_full,
    input  logic [7:0]      mem_din,
    output logic [7:0]      mem_dout,
    output logic [XLEN-1:0] mem_a,
    output logic            mem_wr,
    input  logic            lsb_mem_enable,
    input  logic [OP_W-1:0] lsb_mem_op,
    input  logic [XLEN-1:0] lsb_mem_addr,
    input  logic [ID_W-1:0] lsb_mem_id,
    input  logic            rob_mem_enable,
    input  logic [OP_W-1:0] rob_mem_op,
    input  logic [XLEN-1:0] rob_mem_addr,
    input  logic [XLEN-1:0] rob_mem_val,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic            mem_busy,
    output logic            mem_data_ready,
    output logic [XLEN-1:0] mem_data,
    output logic [ID_W-1:0] mem_id
);
    // Ops use RISC-V funct3 codes: LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5.
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WAIT_IO} state_t;

    function automatic logic [2:0] nbytes(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU: nbytes = 3'd1;
            OP_LH, OP_LHU: nbytes = 3'd2;
            default:       nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [OP_W-1:0] op, input logic [XLEN-1:0] w);
        case (op)
            OP_LB:   extend = {{(XLEN-8){w[7]}}, w[7:0]};
            OP_LH:   extend = {{(XLEN-16){w[15]}}, w[15:0]};
            OP_LBU:  extend = {{(XLEN-8){1'b0}}, w[7:0]};
            OP_LHU:  extend = {{(XLEN-16){1'b0}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d, n_q, n_d;
    logic [XLEN-1:0]   addr_q, addr_d, data_q, data_d, wdata_q, wdata_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              is_fetch_q, is_fetch_d;
    logic [1:0]        skip_q, skip_d;
    logic              st_pend_q, st_pend_d, ld_pend_q, ld_pend_d;
    logic [OP_W-1:0]   st_op_q, st_op_d, ld_op_q, ld_op_d;
    logic [XLEN-1:0]   st_addr_q, st_addr_d, st_val_q, st_val_d, ld_addr_q, ld_addr_d;
    logic [ID_W-1:0]   ld_id_q, ld_id_d;
    logic [XLEN-1:0]   mem_a_q, mem_a_d, if_inst_q, if_inst_d, mem_data_q, mem_data_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d, if_ready_q, if_ready_d, mem_data_ready_q, mem_data_ready_d;
    logic [ID_W-1:0]   mem_id_q, mem_id_d;

    logic              st_any, ld_any, grant_fetch, ld_from_pulse;
    logic [OP_W-1:0]   st_sel_op, ld_sel_op;
    logic [XLEN-1:0]   st_sel_addr, st_sel_val, ld_sel_addr;
    logic [ID_W-1:0]   ld_sel_id;
    logic [1:0]        rx_idx, tx_idx;

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  n_d = n_q;  addr_d = addr_q;
        op_d = op_q;  id_d = id_q;  is_fetch_d = is_fetch_q;  skip_d = skip_q;
        data_d = data_q;  wdata_d = wdata_q;
        st_pend_d = st_pend_q;  st_op_d = st_op_q;  st_addr_d = st_addr_q;  st_val_d = st_val_q;
        ld_pend_d = ld_pend_q;  ld_op_d = ld_op_q;  ld_addr_d = ld_addr_q;  ld_id_d = ld_id_q;
        mem_a_d = mem_a_q;  mem_dout_d = mem_dout_q;  mem_wr_d = 1'b0;
        if_inst_d = if_inst_q;  if_ready_d = 1'b0;
        mem_data_ready_d = 1'b0;  mem_data_d = '0;  mem_id_d = '1;
        ld_from_pulse = 1'b0;

        st_any      = st_pend_q | rob_mem_enable;
        st_sel_op   = st_pend_q ? st_op_q   : rob_mem_op;
        st_sel_addr = st_pend_q ? st_addr_q : rob_mem_addr;
        st_sel_val  = st_pend_q ? st_val_q  : rob_mem_val;
        ld_any      = (ld_pend_q | lsb_mem_enable) & ~flush;
        ld_sel_op   = ld_pend_q ? ld_op_q   : lsb_mem_op;
        ld_sel_addr = ld_pend_q ? ld_addr_q : lsb_mem_addr;
        ld_sel_id   = ld_pend_q ? ld_id_q   : lsb_mem_id;
        // After two store/load grants past a waiting fetch, the fetch jumps the queue.
        // No fetch is granted while if_ready is pulsing: the fetch unit has not yet dropped if_req.
        grant_fetch = if_req & ~flush & ~if_ready_q & ((skip_q == 2'd2) | (~st_any & ~ld_any));
        rx_idx = 2'(cnt_q - 3'd1);
        tx_idx = 2'(cnt_q + 3'd1);

        case (state_q)
            S_IDLE: begin
                if (grant_fetch) begin
                    state_d = S_READ;  addr_d = if_addr;  n_d = 3'd4;  is_fetch_d = 1'b1;
                    cnt_d = 3'd0;  data_d = '0;  mem_a_d = if_addr;  skip_d = 2'd0;
                end else if (st_any) begin
                    addr_d = st_sel_addr;  n_d = nbytes(st_sel_op);  wdata_d = st_sel_val;
                    cnt_d = 3'd0;  mem_a_d = st_sel_addr;  mem_dout_d = st_sel_val[7:0];
                    if (if_req && skip_q != 2'd2) skip_d = skip_q + 2'd1;
                    if (st_sel_addr == IO_ADDR && io_buffer_full) begin
                        state_d = S_WAIT_IO;
                    end else begin
                        state_d = S_WRITE;  mem_wr_d = 1'b1;
                    end
                end else if (ld_any) begin
                    state_d = S_READ;  addr_d = ld_sel_addr;  n_d = nbytes(ld_sel_op);
                    op_d = ld_sel_op;  id_d = ld_sel_id;  is_fetch_d = 1'b0;
                    cnt_d = 3'd0;  data_d = '0;  mem_a_d = ld_sel_addr;
                    ld_from_pulse = ~ld_pend_q;  ld_pend_d = 1'b0;
                    if (if_req && skip_q != 2'd2) skip_d = skip_q + 2'd1;
                end
            end
            S_READ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q != 3'd0) data_d[8*rx_idx +: 8] = mem_din;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 < n_q) mem_a_d = addr_q + XLEN'(cnt_q + 3'd1);
                    if (cnt_q == n_q) begin
                        state_d = S_IDLE;
                        if (is_fetch_q) begin
                            if_ready_d = 1'b1;  if_inst_d = data_d;
                        end else begin
                            mem_data_ready_d = 1'b1;  mem_data_d = extend(op_q, data_d);  mem_id_d = id_q;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q + 3'd1 < n_q) begin
                    cnt_d = cnt_q + 3'd1;  mem_a_d = addr_q + XLEN'(cnt_q + 3'd1);
                    mem_dout_d = wdata_q[8*tx_idx +: 8];  mem_wr_d = 1'b1;
                end else begin
                    state_d = S_IDLE;  st_pend_d = 1'b0;
                end
            end
            S_WAIT_IO: begin
                if (!io_buffer_full) begin
                    state_d = S_WRITE;  mem_wr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rob_mem_enable) begin
            st_pend_d = 1'b1;  st_op_d = rob_mem_op;  st_addr_d = rob_mem_addr;  st_val_d = rob_mem_val;
        end
        if (flush) begin
            ld_pend_d = 1'b0;
        end else if (lsb_mem_enable && !ld_from_pulse) begin
            ld_pend_d = 1'b1;  ld_op_d = lsb_mem_op;  ld_addr_d = lsb_mem_addr;  ld_id_d = lsb_mem_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  cnt_q <= '0;  n_q <= '0;  addr_q <= '0;  op_q <= '0;  id_q <= '0;
            is_fetch_q <= 1'b0;  skip_q <= '0;  data_q <= '0;  wdata_q <= '0;
            st_pend_q <= 1'b0;  st_op_q <= '0;  st_addr_q <= '0;  st_val_q <= '0;
            ld_pend_q <= 1'b0;  ld_op_q <= '0;  ld_addr_q <= '0;  ld_id_q <= '0;
            mem_a_q <= '0;  mem_dout_q <= '0;  mem_wr_q <= 1'b0;  if_inst_q <= '0;  if_ready_q <= 1'b0;
            mem_data_ready_q <= 1'b0;  mem_data_q <= '0;  mem_id_q <= '1;
        end else if (rdy) begin
            state_q <= state_d;  cnt_q <= cnt_d;  n_q <= n_d;  addr_q <= addr_d;  op_q <= op_d;  id_q <= id_d;
            is_fetch_q <= is_fetch_d;  skip_q <= skip_d;  data_q <= data_d;  wdata_q <= wdata_d;
            st_pend_q <= st_pend_d;  st_op_q <= st_op_d;  st_addr_q <= st_addr_d;  st_val_q <= st_val_d;
            ld_pend_q <= ld_pend_d;  ld_op_q <= ld_op_d;  ld_addr_q <= ld_addr_d;  ld_id_q <= ld_id_d;
            mem_a_q <= mem_a_d;  mem_dout_q <= mem_dout_d;  mem_wr_q <= mem_wr_d;
            if_inst_q <= if_inst_d;  if_ready_q <= if_ready_d;
            mem_data_ready_q <= mem_data_ready_d;  mem_data_q <= mem_data_d;  mem_id_q <= mem_id_d;
        end
    end

    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;
    assign if_ready       = if_ready_q;
    assign if_inst        = if_inst_q;
    assign mem_data_ready = mem_data_ready_q;
    assign mem_data       = mem_data_q;
    assign mem_id         = mem_id_q;
    assign mem_busy       = (state_q != S_IDLE) | ld_pend_q | lsb_mem_enable;
endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - directed and randomized checks of memory_controller against a byte-array memory model
module tb_memory_controller;
    localparam int          ID_W    = 4;
    localparam logic [31:0] IO_ADDR = 32'h30000;
    localparam logic [2:0]  OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd4, OP_LHU = 3'd5;
    localparam logic [2:0]  OP_SB = 3'd0, OP_SH = 3'd1, OP_SW = 3'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, rdy, flush, io_buffer_full;
    logic [7:0]      mem_din, mem_dout;
    logic [31:0]     mem_a;
    logic            mem_wr;
    logic            lsb_mem_enable, rob_mem_enable, if_req;
    logic [2:0]      lsb_mem_op, rob_mem_op;
    logic [31:0]     lsb_mem_addr, rob_mem_addr, rob_mem_val, if_addr, if_inst, mem_data;
    logic [ID_W-1:0] lsb_mem_id, mem_id;
    logic            if_ready, mem_busy, mem_data_ready;

    memory_controller #(.IO_ADDR(IO_ADDR), .XLEN(32), .ID_W(ID_W), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op), .lsb_mem_addr(lsb_mem_addr),
        .lsb_mem_id(lsb_mem_id), .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_val(rob_mem_val), .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_inst(if_inst), .mem_busy(mem_busy), .mem_data_ready(mem_data_ready),
        .mem_data(mem_data), .mem_id(mem_id)
    );

    typedef struct { int cyc; logic [31:0] a; logic [31:0] d; } ev_t;
    ev_t wr_q[$], ld_q[$], if_q[$];

    logic [7:0]  ram [0:65535];
    logic [7:0]  mdl [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    int cyc = 0;
    int checks = 0, errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    always @(negedge clk) begin
        if (mem_wr) wr_q.push_back('{cyc, mem_a, 32'(mem_dout)});
        if (mem_data_ready) ld_q.push_back('{cyc, 32'(mem_id), mem_data});
        if (if_ready) if_q.push_back('{cyc, 32'd0, if_inst});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        longint v = 0;
        int n = nbytes(op);
        for (int k = 0; k < n; k++) v += longint'(mdl[16'(addr + 32'(k))]) << (8 * k);
        if (!op[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_we = 1'b1;  pre_addr = a[15:0];  pre_data = d;  mdl[a[15:0]] = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [ID_W-1:0] id, input logic [31:0] exp);
        int t;
        ev_t e;
        ld_q.delete();
        lsb_mem_enable = 1'b1;  lsb_mem_op = op;  lsb_mem_addr = addr;  lsb_mem_id = id;  t = cyc;
        step();
        lsb_mem_enable = 1'b0;
        for (int i = 0; i < 40 && ld_q.size() == 0; i++) step();
        chk({tag, "_seen"}, 32'(ld_q.size()), 32'd1);
        if (ld_q.size() > 0) begin
            e = ld_q.pop_front();
            chk({tag, "_data"}, e.d, exp);
            chk({tag, "_id"}, e.a, 32'(id));
            chk({tag, "_lat"}, 32'(e.cyc - t), 32'(nbytes(op) + 2));
        end
    endtask

    task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] val);
        int t, n;
        ev_t e;
        n = nbytes(op);
        wr_q.delete();
        rob_mem_enable = 1'b1;  rob_mem_op = op;  rob_mem_addr = addr;  rob_mem_val = val;  t = cyc;
        step();
        rob_mem_enable = 1'b0;
        for (int i = 0; i < 40 && wr_q.size() < n; i++) step();
        step();
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            e = wr_q[k];
            chk({tag, "_wa"}, e.a, addr + 32'(k));
            chk({tag, "_wd"}, e.d, (val >> (8 * k)) & 32'hFF);
            chk({tag, "_wc"}, 32'(e.cyc - t), 32'(1 + k));
        end
        for (int k = 0; k < n; k++) mdl[16'(addr + 32'(k))] = 8'(val >> (8 * k));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_a"}, mem_a, 32'd0);
        chk({tag, "_dout"}, 32'(mem_dout), 32'd0);
        chk({tag, "_ifr"}, 32'(if_ready), 32'd0);
        chk({tag, "_dr"}, 32'(mem_data_ready), 32'd0);
        chk({tag, "_data"}, mem_data, 32'd0);
        chk({tag, "_id"}, 32'(mem_id), 32'hF);
        chk({tag, "_busy"}, 32'(mem_busy), 32'd0);
    endtask

    initial begin
        int t;
        ev_t e;
        logic [31:0] v;
        logic [2:0] lops [5];
        lops[0] = OP_LB;  lops[1] = OP_LH;  lops[2] = OP_LW;  lops[3] = OP_LBU;  lops[4] = OP_LHU;

        rst = 1'b1;  rdy = 1'b1;  flush = 1'b0;  io_buffer_full = 1'b0;  pre_we = 1'b0;
        pre_addr = '0;  pre_data = '0;
        lsb_mem_enable = 1'b0;  lsb_mem_op = '0;  lsb_mem_addr = '0;  lsb_mem_id = '0;
        rob_mem_enable = 1'b0;  rob_mem_op = '0;  rob_mem_addr = '0;  rob_mem_val = '0;
        if_req = 1'b0;  if_addr = '0;
        repeat (3) step();
        chk_reset_outputs("rst0");
        rst = 1'b0;
        step();

        // LW with busy window and fixed latency
        poke(32'h100, 8'h78);  poke(32'h101, 8'h56);  poke(32'h102, 8'h34);  poke(32'h103, 8'h12);
        ld_q.delete();
        t = cyc;
        lsb_mem_enable = 1'b1;  lsb_mem_op = OP_LW;  lsb_mem_addr = 32'h100;  lsb_mem_id = 4'd5;
        for (int i = 0; i <= 6; i++) begin
            #1;
            chk($sformatf("t1_busy%0d", i), 32'(mem_busy), (i <= 5) ? 32'd1 : 32'd0);
            step();
            lsb_mem_enable = 1'b0;
        end
        chk("t1_seen", 32'(ld_q.size()), 32'd1);
        if (ld_q.size() > 0) begin
            e = ld_q.pop_front();
            chk("t1_data", e.d, 32'h12345678);
            chk("t1_id", e.a, 32'd5);
            chk("t1_cyc", 32'(e.cyc - t), 32'd6);
        end

        // Sign and zero extension
        poke(32'h200, 8'h80);
        do_load("t2_lb", OP_LB, 32'h200, 4'd1, 32'hFFFFFF80);
        do_load("t2_lbu", OP_LBU, 32'h200, 4'd2, 32'h00000080);

        // Store, load and fetch in the same cycle
        poke(32'h40, 8'h13);  poke(32'h41, 8'h00);  poke(32'h42, 8'h00);  poke(32'h43, 8'h00);
        wr_q.delete();  ld_q.delete();  if_q.delete();
        v = 32'hAABBCCDD;
        t = cyc;
        rob_mem_enable = 1'b1;  rob_mem_op = OP_SW;  rob_mem_addr = 32'h10;  rob_mem_val = v;
        lsb_mem_enable = 1'b1;  lsb_mem_op = OP_LW;  lsb_mem_addr = 32'h10;  lsb_mem_id = 4'd3;
        if_req = 1'b1;  if_addr = 32'h40;
        step();
        rob_mem_enable = 1'b0;  lsb_mem_enable = 1'b0;
        for (int i = 0; i < 40 && if_q.size() == 0; i++) step();
        if_req = 1'b0;
        chk("t3_nwr", 32'(wr_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            chk("t3_wa", wr_q[k].a, 32'h10 + 32'(k));
            chk("t3_wd", wr_q[k].d, (v >> (8 * k)) & 32'hFF);
            chk("t3_wc", 32'(wr_q[k].cyc - t), 32'(1 + k));
        end
        for (int k = 0; k < 4; k++) mdl[16'h10 + 16'(k)] = 8'(v >> (8 * k));
        chk("t3_ld_seen", 32'(ld_q.size()), 32'd1);
        if (ld_q.size() > 0) begin
            e = ld_q.pop_front();
            chk("t3_ld_data", e.d, 32'hAABBCCDD);
            chk("t3_ld_id", e.a, 32'd3);
            chk("t3_ld_cyc", 32'(e.cyc - t), 32'd11);
        end
        chk("t3_if_seen", 32'(if_q.size()), 32'd1);
        if (if_q.size() > 0) begin
            e = if_q.pop_front();
            chk("t3_if_inst", e.d, 32'h00000013);
            chk("t3_if_cyc", 32'(e.cyc - t), 32'd17);
        end
        repeat (8) step();
        chk("t3_no_extra_fetch", 32'(if_q.size()), 32'd0);

        // IO store held off while the UART buffer is full
        wr_q.delete();
        io_buffer_full = 1'b1;
        t = cyc;
        rob_mem_enable = 1'b1;  rob_mem_op = OP_SB;  rob_mem_addr = IO_ADDR;  rob_mem_val = 32'h41;
        step();
        rob_mem_enable = 1'b0;
        repeat (4) step();
        io_buffer_full = 1'b0;
        repeat (6) step();
        chk("t4_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            chk("t4_wa", wr_q[0].a, IO_ADDR);
            chk("t4_wd", wr_q[0].d, 32'h41);
            chk("t4_wc", 32'(wr_q[0].cyc - t), 32'd6);
        end

        // Flush part-way through a load while a store waits in its slot
        poke(32'h300, 8'h01);  poke(32'h301, 8'h02);  poke(32'h302, 8'h03);  poke(32'h303, 8'h04);
        wr_q.delete();  ld_q.delete();
        t = cyc;
        lsb_mem_enable = 1'b1;  lsb_mem_op = OP_LW;  lsb_mem_addr = 32'h300;  lsb_mem_id = 4'd7;
        step();
        lsb_mem_enable = 1'b0;
        rob_mem_enable = 1'b1;  rob_mem_op = OP_SH;  rob_mem_addr = 32'h50;  rob_mem_val = 32'h5A6B;
        step();
        rob_mem_enable = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_busy_low", 32'(mem_busy), 32'd0);
        repeat (20) step();
        chk("t5_no_ready", 32'(ld_q.size()), 32'd0);
        chk("t5_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            chk("t5_wa0", wr_q[0].a, 32'h50);
            chk("t5_wd0", wr_q[0].d, 32'h6B);
            chk("t5_wc0", 32'(wr_q[0].cyc - t), 32'd6);
            chk("t5_wa1", wr_q[1].a, 32'h51);
            chk("t5_wd1", wr_q[1].d, 32'h5A);
            chk("t5_wc1", 32'(wr_q[1].cyc - t), 32'd7);
        end
        mdl[16'h50] = 8'h6B;  mdl[16'h51] = 8'h5A;

        // Reset in the middle of a write
        rob_mem_enable = 1'b1;  rob_mem_op = OP_SW;  rob_mem_addr = 32'h60;  rob_mem_val = 32'h11223344;
        step();
        rob_mem_enable = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_reset_outputs("t6");
        rst = 1'b0;
        step();
        chk("t6_no_write", 32'(mem_wr), 32'd0);

        // Randomized stores and loads in a scratch region
        for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [2:0]  op;
            a = 32'h1000 + 32'($urandom_range(0, 60));
            if ($urandom_range(0, 2) == 0) begin
                op = 3'($urandom_range(0, 2));
                do_store($sformatf("rs%0d", i), op, a, $urandom);
            end else begin
                op = lops[$urandom_range(0, 4)];
                do_load($sformatf("rl%0d", i), op, a, ID_W'($urandom), ref_load(op, a));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
